// File: rtl/w_grf.sv
// W-stage register file: selects write-back data, commits to 32 GPRs, serves two bypassed D-stage read ports.
// Latency: reads/WD_W combinational; commit and trace registered at the end of the W cycle.
// No backpressure: one write per cycle, always accepted; trace strobe is a single-cycle pulse per write.
module w_grf #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RFWr_W,
  input  logic [1:0]        RSel_W,
  input  logic [AW-1:0]     A3_W,
  input  logic [DATA_W-1:0] ALU_W,
  input  logic [DATA_W-1:0] DM_W,
  input  logic [DATA_W-1:0] PC_W,
  input  logic [AW-1:0]     A1_D,
  input  logic [AW-1:0]     A2_D,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic [DATA_W-1:0] WD_W,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_data,
  output logic [AW-1:0]     wb_addr
);

  logic [DATA_W-1:0] regs [NREG];

  // Register 0 is hard-wired, so a write to it is traced but never committed.
  logic commit;
  assign commit = RFWr_W && (A3_W != '0);

  // Write-data select; the link value is the return address past the delay slot.
  always_comb begin
    WD_W = ALU_W;
    case (RSel_W)
      2'b01:   WD_W = DM_W;
      2'b10:   WD_W = PC_W + DATA_W'(8);
      default: WD_W = ALU_W;
    endcase
  end

  // Architectural register state; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[A3_W] <= WD_W;
    end
  end

  // Read port 1: zero register first, then write-through of the in-flight W write.
  always_comb begin
    RD1_D = regs[A1_D];
    if (A1_D == '0)
      RD1_D = '0;
    else if (RFWr_W && (A3_W == A1_D))
      RD1_D = WD_W;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    RD2_D = regs[A2_D];
    if (A2_D == '0)
      RD2_D = '0;
    else if (RFWr_W && (A3_W == A2_D))
      RD2_D = WD_W;
  end

  // Write-back trace: strobe every write (including r0), payload holds between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= RFWr_W;
      if (RFWr_W) begin
        wb_pc   <= PC_W;
        wb_addr <= A3_W;
        wb_data <= WD_W;
      end
    end
  end

endmodule

// File: tb/tb_w_grf.sv
// Scoreboard bench for w_grf: driver pushes hand-computed expectations, monitor checks every cycle.
// Combinational outputs checked mid-cycle; trace checked one cycle after the write is issued.
// Directed vectors only; runs a few dozen cycles and always finishes.
module tb_w_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RFWr_W = 1'b0;
  logic [1:0]  RSel_W = 2'b00;
  logic [4:0]  A3_W = '0;
  logic [31:0] ALU_W = '0, DM_W = '0, PC_W = '0;
  logic [4:0]  A1_D = '0, A2_D = '0;
  logic [31:0] RD1_D, RD2_D, WD_W;
  logic        wb_valid;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_addr;

  w_grf dut (
    .clk(clk), .reset(reset), .RFWr_W(RFWr_W), .RSel_W(RSel_W), .A3_W(A3_W),
    .ALU_W(ALU_W), .DM_W(DM_W), .PC_W(PC_W), .A1_D(A1_D), .A2_D(A2_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .WD_W(WD_W),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_data(wb_data), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wd;
  } comb_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } trace_t;

  comb_t  comb_q[$];
  trace_t trace_q[$];
  int     total = 0;
  int     bad = 0;
  int     pulses = 0;

  // expected trace payload, held between writes
  logic [31:0] tr_pc = '0, tr_data = '0;
  logic [4:0]  tr_addr = '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one W/D cycle and queue what the DUT must show for it.
  task automatic step(input logic rst, input logic we, input logic [1:0] sel,
                      input logic [4:0] a3, input logic [31:0] alu, input logic [31:0] dm,
                      input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                      input logic chk, input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ew);
    comb_t  c;
    trace_t t;
    @(posedge clk);
    #1;
    reset = rst; RFWr_W = we; RSel_W = sel; A3_W = a3;
    ALU_W = alu; DM_W = dm; PC_W = pc; A1_D = a1; A2_D = a2;
    c.chk = chk; c.rd1 = e1; c.rd2 = e2; c.wd = ew;
    comb_q.push_back(c);
    if (rst) begin
      tr_pc = '0; tr_addr = '0; tr_data = '0;
    end else if (we) begin
      tr_pc = pc; tr_addr = a3; tr_data = ew;
    end
    t.v = we & ~rst; t.pc = tr_pc; t.addr = tr_addr; t.data = tr_data;
    trace_q.push_back(t);
  endtask

  // Monitor: mid-cycle, compare combinational outputs for this cycle and trace from the previous edge.
  initial begin
    comb_t  c;
    trace_t t;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        if (c.chk) begin
          cmp("rd1", RD1_D, c.rd1);
          cmp("rd2", RD2_D, c.rd2);
          cmp("wd", WD_W, c.wd);
        end
      end
      if (trace_q.size() >= 2) begin
        t = trace_q.pop_front();
        if (wb_valid) pulses++;
        cmp("wb_valid", {31'd0, wb_valid}, {31'd0, t.v});
        cmp("wb_pc", wb_pc, t.pc);
        cmp("wb_addr", {27'd0, wb_addr}, {27'd0, t.addr});
        cmp("wb_data", wb_data, t.data);
      end
    end
  end

  // Driver: directed vectors with hand-computed expectations.
  initial begin
    //   rst we sel   a3  alu           dm            pc            a1  a2   chk rd1           rd2           wd
    step(1, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        0,  0,   0,  32'h0,        32'h0,        32'h0);
    for (int i = 0; i < 16; i++)
      step(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(i + 16), 1, 32'h0, 32'h0, 32'h0);
    // write r5 via ALU, bypassed same cycle, then read from the array
    step(0, 1, 2'd0, 5,  32'h12345678, 32'h0,        32'h00001000, 5,  0,   1,  32'h12345678, 32'h0,        32'h12345678);
    step(0, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        5,  5,   1,  32'h12345678, 32'h12345678, 32'h0);
    // link writes: PC+8, including wrap past 2^32
    step(0, 1, 2'd2, 31, 32'h1111,     32'h2222,     32'h00003000, 31, 5,   1,  32'h00003008, 32'h12345678, 32'h00003008);
    step(0, 1, 2'd2, 30, 32'h1111,     32'h2222,     32'hFFFFFFFC, 31, 30,  1,  32'h00003008, 32'h00000004, 32'h00000004);
    // write to r0: traced, never visible
    step(0, 1, 2'd1, 0,  32'h1111,     32'hDEADBEEF, 32'h00002000, 0,  0,   1,  32'h0,        32'h0,        32'hDEADBEEF);
    step(0, 0, 2'd3, 0,  32'h0000CAFE, 32'h0,        32'h0,        0,  30,  1,  32'h0,        32'h00000004, 32'h0000CAFE);
    // back-to-back writes to r7, both ports bypass each in its own cycle
    step(0, 1, 2'd0, 7,  32'hAAAA0000, 32'h0,        32'h00004000, 7,  7,   1,  32'hAAAA0000, 32'hAAAA0000, 32'hAAAA0000);
    step(0, 1, 2'd3, 7,  32'h0000BBBB, 32'h0,        32'h00004004, 7,  7,   1,  32'h0000BBBB, 32'h0000BBBB, 32'h0000BBBB);
    step(0, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        7,  7,   1,  32'h0000BBBB, 32'h0000BBBB, 32'h0);
    // write r9, then reset with a competing write: bypass still shows WD_W, nothing commits
    step(0, 1, 2'd0, 9,  32'h00000055, 32'h0,        32'h00005000, 9,  0,   1,  32'h00000055, 32'h0,        32'h00000055);
    step(1, 1, 2'd0, 9,  32'h00000077, 32'h0,        32'h00005004, 9,  7,   1,  32'h00000077, 32'h0000BBBB, 32'h00000077);
    step(0, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        9,  7,   1,  32'h0,        32'h0,        32'h0);
    step(0, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        31, 5,   1,  32'h0,        32'h0,        32'h0);
    step(0, 0, 2'd0, 0,  32'h0,        32'h0,        32'h0,        0,  0,   0,  32'h0,        32'h0,        32'h0);
    @(negedge clk);
    @(negedge clk);
    // pulses: r5, r31, r30, r0, r7, r7, r9
    cmp("pulse_count", 32'(pulses), 32'd7);
    cmp("comb_q_drained", 32'(comb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
